stack_lander: RTL and testbench
===============================

// Module: stack_lander
// PURPOSE
//  Consumer side of the block-shift interface in the stacker game. On a stop-button press it
//  latches the moving row from the shifter, ANDs it with the row below, and commits the overlap
//  to an 8-row stack. The overlap becomes the shifter's next seed (newBlock + one-cycle
//  loadNext). Also tracks score and detects game-over (zero overlap) and win (top row placed).
// PARAMETERS
//  ROWS        8             stack height; row 0 = bottom
//  WIDTH       8             columns; fixed to match the shifter's 8-bit blockLoc
//  INIT_BLOCK  8'b0001_1100  seed block after reset/restart (width 3)
//  SCORE_W     7             score width; must hold ROWS*WIDTH (64)
// PORTS
//  clk         in   1        game clock, the same clock that drives the shifter
//  rst         in   1        synchronous, active-high reset
//  stopBtn     in   1        stop button, level, synchronous to clk
//  restartBtn  in   1        restart button, level, synchronous to clk
//  blockLoc    in   WIDTH    current moving-row position from the shifter
//  newBlock    out  WIDTH    seed for the next row (last committed overlap)
//  loadNext    out  1        one-cycle pulse: shifter must reload from newBlock
//  rowIdx      out  3        row currently being played
//  rdRow       in   3        display read address
//  rdData      out  WIDTH    stack[rdRow], combinational read
//  score       out  SCORE_W  running count of placed cells
//  gameOver    out  1        high (sticky) after a miss
//  win         out  1        high (sticky) after the top row is committed
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): all stack rows=0, rowIdx=0, newBlock=INIT_BLOCK, loadNext=1
//    for the next cycle (seeds the shifter), score=0, gameOver=0, win=0, state=LOAD.
//  - Edges: stopEdge = stopBtn & ~stopPrev; restartEdge likewise. Prev registers reset to 1, so
//    a button held through reset does not fire. Held buttons give exactly one edge.
//  - FSM states: ARMED, COMPARE, COMMIT, LOAD, OVER, WIN.
//    ARMED:   on stopEdge, landed <= blockLoc, then COMPARE. Stop edges in other states are dropped.
//    COMPARE: overlap = (rowIdx==0) ? landed : landed & stack[rowIdx-1].
//             overlap==0 -> OVER, else COMMIT.
//    COMMIT:  stack[rowIdx] <= overlap; newBlock <= overlap; score += popcount(overlap).
//             If rowIdx==ROWS-1 go to WIN, else rowIdx++ and go to LOAD.
//    LOAD:    loadNext=1 for exactly this cycle, then ARMED.
//    OVER:    gameOver=1, held. WIN: win=1, held. Only restartEdge or rst leaves either state.
//  - Latency: stopEdge sampled at edge t gives the stack write at edge t+2 and loadNext high
//    between edges t+2 and t+3. Miss: gameOver high from edge t+2.
//  - loadNext, gameOver and win are registered outputs (decoded from registered state, no
//    combinational path from the inputs).
//  - restartEdge in any state behaves exactly like rst on the next edge. If restartEdge and
//    stopEdge arrive in the same cycle, restart wins.
//  - rdRow >= ROWS is impossible for ROWS=8. For smaller ROWS, rdData=0 in that case.
//  - Score arithmetic: popcount is 4 bits, zero-extended into SCORE_W. No wrap is possible at
//    the defaults.
//  - The overlap is never widened; a block can only shrink or stay the same width.
// STRUCTURE
//  - stack_pkg: state encoding localparams, INIT_BLOCK, ROWS, WIDTH, popcount function.
//  - One sub-module, btn_edge (registered rising-edge detector with reset value 1),
//    instantiated for stopBtn and restartBtn.
//  - Stack storage is an 8x8 register array (not RAM), so the async read port works.
// TESTING
//  1 rst 2 cycles -> newBlock=8'h1C, loadNext pulses 1 cycle, rowIdx=0, score=0, rdData=0 all rows.
//  2 row0 stop with blockLoc=8'h38 -> stack[0]=8'h38, newBlock=8'h38, score=3, rowIdx=1,
//    loadNext at t+2.
//  3 row1 stop with blockLoc=8'h70 over 8'h38 -> stack[1]=8'h30, newBlock=8'h30, score=5.
//  4 row2 stop with blockLoc=8'h03 over 8'h30 -> gameOver=1 at t+2, no loadNext, stack[2]=0.
//    Further stops are ignored.
//  5 eight aligned stops with blockLoc=8'h1C -> win=1, score=24, rowIdx=7, no loadNext after
//    the last commit.
//  6 stopBtn held 10 cycles gives one commit. restartBtn and stopBtn rising together mid-game
//    -> full clear, newBlock=8'h1C.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants, FSM state encoding and helpers for the stacker game's landing logic.
package stack_pkg;

  localparam int ROWS    = 8;
  localparam int WIDTH   = 8;
  localparam int SCORE_W = 7;

  localparam logic [WIDTH-1:0] INIT_BLOCK = 8'b0001_1100;

  typedef enum logic [2:0] {
    ST_ARMED   = 3'd0,
    ST_COMPARE = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_LOAD    = 3'd3,
    ST_OVER    = 3'd4,
    ST_WIN     = 3'd5
  } state_e;

  function automatic logic [3:0] popcount(input logic [WIDTH-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a level button; the history flop resets high so a
// button held through reset does not produce an edge.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = btn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/stack_lander.sv
// Consumer side of the block-shift interface: latches the moving row on a stop press,
// trims it against the row below, commits it to the stack and seeds the shifter.
module stack_lander
  import stack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stopBtn,
  input  logic               restartBtn,
  input  logic [WIDTH-1:0]   blockLoc,
  output logic [WIDTH-1:0]   newBlock,
  output logic               loadNext,
  output logic [2:0]         rowIdx,
  input  logic [2:0]         rdRow,
  output logic [WIDTH-1:0]   rdData,
  output logic [SCORE_W-1:0] score,
  output logic               gameOver,
  output logic               win,
  output state_e             state_dbg
);

  logic stop_edge;
  logic restart_edge;

  btn_edge u_stop_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (stopBtn),
    .rise (stop_edge)
  );

  btn_edge u_restart_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (restartBtn),
    .rise (restart_edge)
  );

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   stack_q [ROWS];
  logic [WIDTH-1:0]   stack_d [ROWS];
  logic [WIDTH-1:0]   landed_q, landed_d;
  logic [WIDTH-1:0]   overlap_q, overlap_d;
  logic [WIDTH-1:0]   new_block_q, new_block_d;
  logic [2:0]         row_idx_q, row_idx_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               load_next_q, load_next_d;
  logic               game_over_q, game_over_d;
  logic               win_q, win_d;
  logic [WIDTH-1:0]   overlap_calc;

  // Row 0 has nothing underneath, so the landed row is taken as-is.
  assign overlap_calc = (row_idx_q == 3'd0) ? landed_q
                                            : (landed_q & stack_q[row_idx_q - 3'd1]);

  always_comb begin
    state_d     = state_q;
    stack_d     = stack_q;
    landed_d    = landed_q;
    overlap_d   = overlap_q;
    new_block_d = new_block_q;
    row_idx_d   = row_idx_q;
    score_d     = score_q;

    case (state_q)
      ST_ARMED: begin
        if (stop_edge) begin
          landed_d = blockLoc;
          state_d  = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        overlap_d = overlap_calc;
        state_d   = (overlap_calc == '0) ? ST_OVER : ST_COMMIT;
      end
      ST_COMMIT: begin
        stack_d[row_idx_q] = overlap_q;
        new_block_d        = overlap_q;
        score_d            = score_q + SCORE_W'(popcount(overlap_q));
        if (row_idx_q == 3'(ROWS - 1)) begin
          state_d = ST_WIN;
        end else begin
          row_idx_d = row_idx_q + 3'd1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = ST_ARMED;
      ST_OVER:  state_d = ST_OVER;
      ST_WIN:   state_d = ST_WIN;
      default:  state_d = ST_LOAD;
    endcase

    load_next_d = (state_d == ST_LOAD);
    game_over_d = game_over_q | (state_q == ST_OVER);
    win_d       = win_q | (state_q == ST_WIN);

    // A restart press is a soft reset and overrides anything decided above.
    if (restart_edge) begin
      state_d     = ST_LOAD;
      for (int r = 0; r < ROWS; r++) stack_d[r] = '0;
      landed_d    = '0;
      overlap_d   = '0;
      new_block_d = INIT_BLOCK;
      row_idx_d   = '0;
      score_d     = '0;
      load_next_d = 1'b1;
      game_over_d = 1'b0;
      win_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      for (int r = 0; r < ROWS; r++) stack_q[r] <= '0;
      landed_q    <= '0;
      overlap_q   <= '0;
      new_block_q <= INIT_BLOCK;
      row_idx_q   <= '0;
      score_q     <= '0;
      load_next_q <= 1'b1;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stack_q     <= stack_d;
      landed_q    <= landed_d;
      overlap_q   <= overlap_d;
      new_block_q <= new_block_d;
      row_idx_q   <= row_idx_d;
      score_q     <= score_d;
      load_next_q <= load_next_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  generate
    if (ROWS == 8) begin : g_full_rd
      assign rdData = stack_q[rdRow];
    end else begin : g_part_rd
      assign rdData = (int'(rdRow) < ROWS) ? stack_q[rdRow] : '0;
    end
  endgenerate

  assign newBlock  = new_block_q;
  assign loadNext  = load_next_q;
  assign rowIdx    = row_idx_q;
  assign score     = score_q;
  assign gameOver  = game_over_q;
  assign win       = win_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stack_lander.sv
// Directed bench for stack_lander: reset, hit/trim/miss, full win, held and simultaneous buttons.
module tb_stack_lander;
  import stack_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         stopBtn;
  logic         restartBtn;
  logic [7:0]   blockLoc;
  logic [2:0]   rdRow;
  logic [7:0]   newBlock;
  logic         loadNext;
  logic [2:0]   rowIdx;
  logic [7:0]   rdData;
  logic [6:0]   score;
  logic         gameOver;
  logic         win;
  state_e       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  stack_lander dut (
    .clk        (clk),
    .rst        (rst),
    .stopBtn    (stopBtn),
    .restartBtn (restartBtn),
    .blockLoc   (blockLoc),
    .newBlock   (newBlock),
    .loadNext   (loadNext),
    .rowIdx     (rowIdx),
    .rdRow      (rdRow),
    .rdData     (rdData),
    .score      (score),
    .gameOver   (gameOver),
    .win        (win),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Press stop for one cycle and follow the commit pipeline to t+3.
  task automatic do_stop(input logic [7:0] blk, input logic exp_load, input logic exp_over);
    blockLoc = blk;
    stopBtn  = 1'b1;
    tick();
    stopBtn  = 1'b0;
    n_checks++; if (state_dbg !== ST_COMPARE) begin $display("FAIL stop_state_t0 got=%0d exp=%0d", state_dbg, ST_COMPARE); n_fail++; end
    tick();
    n_checks++; if (loadNext !== 1'b0) begin $display("FAIL stop_load_t1 got=%b exp=0", loadNext); n_fail++; end
    tick();
    n_checks++; if (loadNext !== exp_load) begin $display("FAIL stop_load_t2 got=%b exp=%b", loadNext, exp_load); n_fail++; end
    n_checks++; if (gameOver !== exp_over) begin $display("FAIL stop_over_t2 got=%b exp=%b", gameOver, exp_over); n_fail++; end
    tick();
    n_checks++; if (loadNext !== 1'b0) begin $display("FAIL stop_load_t3 got=%b exp=0", loadNext); n_fail++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; stopBtn = 1'b1; restartBtn = 1'b0; blockLoc = 8'h00; rdRow = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (loadNext !== 1'b1) begin $display("FAIL rst_load got=%b exp=1", loadNext); n_fail++; end
    n_checks++; if (newBlock !== 8'h1C) begin $display("FAIL rst_newblock got=%h exp=1c", newBlock); n_fail++; end
    n_checks++; if (rowIdx !== 3'd0) begin $display("FAIL rst_rowidx got=%0d exp=0", rowIdx); n_fail++; end
    n_checks++; if (score !== 7'd0) begin $display("FAIL rst_score got=%0d exp=0", score); n_fail++; end
    n_checks++; if (gameOver !== 1'b0 || win !== 1'b0) begin $display("FAIL rst_flags got=%b%b exp=00", gameOver, win); n_fail++; end
    n_checks++; if (state_dbg !== ST_LOAD) begin $display("FAIL rst_state got=%0d exp=%0d", state_dbg, ST_LOAD); n_fail++; end
    for (int r = 0; r < 8; r++) begin
      rdRow = 3'(r);
      #1;
      n_checks++; if (rdData !== 8'h00) begin $display("FAIL rst_rddata row=%0d got=%h exp=00", r, rdData); n_fail++; end
    end
    tick();
    n_checks++; if (loadNext !== 1'b0) begin $display("FAIL rst_load_pulse got=%b exp=0", loadNext); n_fail++; end
    // Stop held through reset must not count as a press.
    tick();
    tick();
    n_checks++; if (state_dbg !== ST_ARMED) begin $display("FAIL rst_held_stop_state got=%0d exp=%0d", state_dbg, ST_ARMED); n_fail++; end
    stopBtn = 1'b0;
    tick();
  endtask

  task automatic test_row0();
    do_stop(8'h38, 1'b1, 1'b0);
    rdRow = 3'd0; #1;
    n_checks++; if (rdData !== 8'h38) begin $display("FAIL row0_stack got=%h exp=38", rdData); n_fail++; end
    n_checks++; if (newBlock !== 8'h38) begin $display("FAIL row0_newblock got=%h exp=38", newBlock); n_fail++; end
    n_checks++; if (score !== 7'd3) begin $display("FAIL row0_score got=%0d exp=3", score); n_fail++; end
    n_checks++; if (rowIdx !== 3'd1) begin $display("FAIL row0_rowidx got=%0d exp=1", rowIdx); n_fail++; end
  endtask

  task automatic test_row1_trim();
    do_stop(8'h70, 1'b1, 1'b0);
    rdRow = 3'd1; #1;
    n_checks++; if (rdData !== 8'h30) begin $display("FAIL row1_stack got=%h exp=30", rdData); n_fail++; end
    n_checks++; if (newBlock !== 8'h30) begin $display("FAIL row1_newblock got=%h exp=30", newBlock); n_fail++; end
    n_checks++; if (score !== 7'd5) begin $display("FAIL row1_score got=%0d exp=5", score); n_fail++; end
    n_checks++; if (rowIdx !== 3'd2) begin $display("FAIL row1_rowidx got=%0d exp=2", rowIdx); n_fail++; end
  endtask

  task automatic test_miss();
    do_stop(8'h03, 1'b0, 1'b1);
    rdRow = 3'd2; #1;
    n_checks++; if (rdData !== 8'h00) begin $display("FAIL miss_stack got=%h exp=00", rdData); n_fail++; end
    n_checks++; if (state_dbg !== ST_OVER) begin $display("FAIL miss_state got=%0d exp=%0d", state_dbg, ST_OVER); n_fail++; end
    n_checks++; if (newBlock !== 8'h30) begin $display("FAIL miss_newblock got=%h exp=30", newBlock); n_fail++; end
    blockLoc = 8'h1C; stopBtn = 1'b1;
    tick();
    stopBtn = 1'b0;
    tick();
    tick();
    n_checks++; if (score !== 7'd5) begin $display("FAIL miss_ignored_score got=%0d exp=5", score); n_fail++; end
    n_checks++; if (gameOver !== 1'b1) begin $display("FAIL miss_sticky got=%b exp=1", gameOver); n_fail++; end
    n_checks++; if (loadNext !== 1'b0) begin $display("FAIL miss_noload got=%b exp=0", loadNext); n_fail++; end
    n_checks++; if (rowIdx !== 3'd2) begin $display("FAIL miss_rowidx got=%0d exp=2", rowIdx); n_fail++; end
  endtask

  task automatic test_restart_from_end();
    restartBtn = 1'b1;
    tick();
    n_checks++; if (state_dbg !== ST_LOAD) begin $display("FAIL restart_state got=%0d exp=%0d", state_dbg, ST_LOAD); n_fail++; end
    n_checks++; if (loadNext !== 1'b1) begin $display("FAIL restart_load got=%b exp=1", loadNext); n_fail++; end
    n_checks++; if (newBlock !== 8'h1C) begin $display("FAIL restart_newblock got=%h exp=1c", newBlock); n_fail++; end
    n_checks++; if (score !== 7'd0 || rowIdx !== 3'd0) begin $display("FAIL restart_counts got=%0d/%0d exp=0/0", score, rowIdx); n_fail++; end
    n_checks++; if (gameOver !== 1'b0 || win !== 1'b0) begin $display("FAIL restart_flags got=%b%b exp=00", gameOver, win); n_fail++; end
    restartBtn = 1'b0;
    tick();
  endtask

  task automatic test_win();
    for (int i = 0; i < 8; i++) begin
      do_stop(8'h1C, (i != 7), 1'b0);
    end
    n_checks++; if (win !== 1'b1) begin $display("FAIL win_flag got=%b exp=1", win); n_fail++; end
    n_checks++; if (score !== 7'd24) begin $display("FAIL win_score got=%0d exp=24", score); n_fail++; end
    n_checks++; if (rowIdx !== 3'd7) begin $display("FAIL win_rowidx got=%0d exp=7", rowIdx); n_fail++; end
    n_checks++; if (state_dbg !== ST_WIN) begin $display("FAIL win_state got=%0d exp=%0d", state_dbg, ST_WIN); n_fail++; end
    for (int r = 0; r < 8; r++) begin
      rdRow = 3'(r);
      #1;
      n_checks++; if (rdData !== 8'h1C) begin $display("FAIL win_stack row=%0d got=%h exp=1c", r, rdData); n_fail++; end
    end
    tick();
    tick();
    n_checks++; if (win !== 1'b1 || loadNext !== 1'b0) begin $display("FAIL win_hold got=%b%b exp=10", win, loadNext); n_fail++; end
  endtask

  task automatic test_back_to_back();
    int pulses;
    blockLoc = 8'h1C;
    stopBtn  = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (loadNext) pulses++;
    end
    stopBtn = 1'b0;
    tick();
    tick();
    n_checks++; if (pulses !== 1) begin $display("FAIL held_pulses got=%0d exp=1", pulses); n_fail++; end
    n_checks++; if (score !== 7'd3) begin $display("FAIL held_score got=%0d exp=3", score); n_fail++; end
    n_checks++; if (rowIdx !== 3'd1) begin $display("FAIL held_rowidx got=%0d exp=1", rowIdx); n_fail++; end
    // Restart and stop rising together: restart must win.
    blockLoc   = 8'hFF;
    stopBtn    = 1'b1;
    restartBtn = 1'b1;
    tick();
    rdRow = 3'd0; #1;
    n_checks++; if (state_dbg !== ST_LOAD) begin $display("FAIL both_state got=%0d exp=%0d", state_dbg, ST_LOAD); n_fail++; end
    n_checks++; if (rdData !== 8'h00) begin $display("FAIL both_stack got=%h exp=00", rdData); n_fail++; end
    n_checks++; if (newBlock !== 8'h1C) begin $display("FAIL both_newblock got=%h exp=1c", newBlock); n_fail++; end
    n_checks++; if (score !== 7'd0 || rowIdx !== 3'd0) begin $display("FAIL both_counts got=%0d/%0d exp=0/0", score, rowIdx); n_fail++; end
    n_checks++; if (loadNext !== 1'b1) begin $display("FAIL both_load got=%b exp=1", loadNext); n_fail++; end
    stopBtn    = 1'b0;
    restartBtn = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (state_dbg !== ST_ARMED || score !== 7'd0) begin $display("FAIL both_after got=%0d/%0d exp=%0d/0", state_dbg, score, ST_ARMED); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_row0();
    test_row1_trim();
    test_miss();
    test_restart_from_end();
    test_win();
    test_restart_from_end();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
